qsub_seq: RTL and testbench

QSUB_SEQ -- requirements
Module: qsub_seq

---
 rtl/qsub_seq.sv | 114 +++++++++++
 tb/tb_qsub_seq.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/qsub_seq.sv
// Sequential sign-magnitude subtractor c = a - b with saturation.
// One request in flight: IDLE captures operands, CALC writes c/ovf, DONE pulses complete.
module qsub_seq #(
  parameter int Q = 15,
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] c,
  output logic         busy,
  output logic         complete,
  output logic         ovf,
  output logic [1:0]   dbg_state_o
);

  // Magnitude is the integer part plus the Q fractional bits.
  localparam int MAG_W = (N - 1 - Q) + Q;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]   state_q, state_d;
  logic [N-1:0] a_q, a_d;
  logic [N-1:0] b_q, b_d;
  logic [N-1:0] c_q, c_d;
  logic         ovf_q, ovf_d;

  logic [MAG_W-1:0] mag_a, mag_b, res_mag;
  logic [MAG_W:0]   sum;
  logic             sgn_a, sgn_b, res_sgn, res_ovf;

  // Handshake: start is a request accepted only on an edge where busy=0;
  // the result is valid in c/ovf during the single cycle complete=1, and
  // start seen while busy=1 is dropped rather than queued.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          state_d = CALC;
        end
      end
      CALC: begin
        c_d     = {res_sgn, res_mag};
        ovf_d   = res_ovf;
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Zero magnitudes get sign 0 so negative-zero inputs behave as plain zero.
  always_comb begin
    mag_a   = a_q[MAG_W-1:0];
    mag_b   = b_q[MAG_W-1:0];
    sgn_a   = a_q[N-1] & (mag_a != '0);
    sgn_b   = ~b_q[N-1] & (mag_b != '0);
    sum     = {1'b0, mag_a} + {1'b0, mag_b};
    res_ovf = 1'b0;
    res_sgn = sgn_a;
    res_mag = sum[MAG_W-1:0];
    if (sgn_a == sgn_b) begin
      if (sum[MAG_W]) begin
        res_ovf = 1'b1;
        res_mag = '1;
      end
    end else if (mag_a > mag_b) begin
      res_mag = mag_a - mag_b;
      res_sgn = sgn_a;
    end else if (mag_b > mag_a) begin
      res_mag = mag_b - mag_a;
      res_sgn = sgn_b;
    end else begin
      res_mag = '0;
    end
    if (res_mag == '0) begin
      res_sgn = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      ovf_q   <= ovf_d;
    end
  end

  assign c           = c_q;
  assign ovf         = ovf_q;
  assign busy        = (state_q != IDLE);
  assign complete    = (state_q == DONE);
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_qsub_seq.sv
// Bench for qsub_seq: driver tasks push predicted results, a negedge monitor
// pops them whenever complete is high and checks value, ovf and arrival cycle.
module tb_qsub_seq;

  localparam int N = 32;
  localparam int Q = 15;
  localparam int W = N + 1 + 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [N-1:0] a = '0;
  logic [N-1:0] b = '0;
  logic [N-1:0] c;
  logic         busy, complete, ovf;
  logic [1:0]   dbg_state;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int n_complete = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_e;
  logic [N-1:0] last_c = '0;
  logic         last_ovf = 1'b0;

  qsub_seq #(.Q(Q), .N(N)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .c(c), .busy(busy), .complete(complete), .ovf(ovf),
    .dbg_state_o(dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, expv);
    end
  endtask

  // Reference: signed integer difference, saturated to the magnitude range.
  function automatic logic [N:0] model(input logic [N-1:0] x, input logic [N-1:0] y);
    longint vx, vy, d, mag, lim;
    logic [N-1:0] r;
    vx  = longint'(x[N-2:0]);
    vy  = longint'(y[N-2:0]);
    if (x[N-1]) vx = -vx;
    if (y[N-1]) vy = -vy;
    d   = vx - vy;
    mag = (d < 0) ? -d : d;
    lim = (longint'(1) << (N - 1)) - 1;
    if (mag > lim) begin
      r = {(d < 0), lim[N-2:0]};
      return {1'b1, r};
    end
    r = {(d < 0), mag[N-2:0]};
    return {1'b0, r};
  endfunction

  function automatic logic [N-1:0] rand_op(input int mode);
    logic [N-1:0] v;
    v = $urandom();
    case (mode)
      0: v = $urandom();
      1: v = {v[N-1], 15'd0, v[15:0]};
      2: v = {v[N-1], 31'h7FFF0000 | {15'd0, v[15:0]}};
      default: v = {v[N-1], 31'd0};
    endcase
    return v;
  endfunction

  // Scoreboard monitor
  always @(negedge clk) begin
    if (rst_n && complete) begin
      n_complete++;
      if (exp_q.size() == 0) begin
        check("unexpected_complete", 64'd1, 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("c", 64'(c), 64'(mon_e[W-1 -: N]));
        check("ovf", 64'(ovf), 64'(mon_e[32]));
        check("latency", 64'(cyc), 64'(mon_e[31:0]));
      end
    end
  end

  // Driver tasks (called at a negedge)
  task automatic wait_idle();
    int n = 0;
    while (busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (busy) check("wait_idle_timeout", 64'd1, 64'd0);
  endtask

  task automatic push_exp(input logic [N-1:0] ce, input logic oe);
    exp_q.push_back({ce, oe, 32'(cyc + 2)});
    last_c   = ce;
    last_ovf = oe;
  endtask

  task automatic issue_exp(input logic [N-1:0] ai, input logic [N-1:0] bi,
                           input logic [N-1:0] ce, input logic oe);
    wait_idle();
    a = ai;
    b = bi;
    start = 1'b1;
    push_exp(ce, oe);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic issue(input logic [N-1:0] ai, input logic [N-1:0] bi);
    logic [N:0] m;
    m = model(ai, bi);
    issue_exp(ai, bi, m[N-1:0], m[N]);
  endtask

  initial begin
    int next_ok, c0, n;
    logic [N:0] m;

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_c", 64'(c), 64'd0);
    check("rst_ovf", 64'(ovf), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_complete", 64'(complete), 64'd0);
    rst_n = 1'b1;

    // Directed vectors; the first one is sampled on the first edge after reset.
    issue_exp(32'h0001C000, 32'h0000A000, 32'h00012000, 1'b0);
    issue_exp(32'h00008000, 32'h00010000, 32'h80008000, 1'b0);
    issue_exp(32'h00008000, 32'h80008000, 32'h00010000, 1'b0);
    issue_exp(32'h00008000, 32'h00008000, 32'h00000000, 1'b0);
    issue_exp(32'h80000000, 32'h00000000, 32'h00000000, 1'b0);
    issue_exp(32'h7FFFFFFF, 32'h80000001, 32'h7FFFFFFF, 1'b1);
    issue_exp(32'h00000002, 32'h00000001, 32'h00000001, 1'b0);
    issue_exp(32'h80000005, 32'h80000005, 32'h00000000, 1'b0);
    issue_exp(32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF, 1'b1);

    // Result holds in IDLE.
    wait_idle();
    repeat (4) @(negedge clk);
    check("hold_c", 64'(c), 64'(last_c));
    check("hold_ovf", 64'(ovf), 64'(last_ovf));

    // start held for 6 cycles with changing operands: two accepted requests.
    wait_idle();
    c0 = n_complete;
    next_ok = cyc + 1;
    for (int i = 0; i < 6; i++) begin
      a = $urandom();
      b = $urandom();
      start = 1'b1;
      if (cyc + 1 >= next_ok) begin
        m = model(a, b);
        push_exp(m[N-1:0], m[N]);
        next_ok = cyc + 1 + 3;
      end
      @(negedge clk);
    end
    start = 1'b0;
    wait_idle();
    repeat (2) @(negedge clk);
    check("held_start_pulses", 64'(n_complete - c0), 64'd2);

    // Reset while in CALC aborts the request.
    wait_idle();
    c0 = n_complete;
    a = 32'h00001234;
    b = 32'h00000034;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    rst_n = 1'b0;
    #1;
    check("abort_c", 64'(c), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_ovf", 64'(ovf), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("abort_no_complete", 64'(n_complete - c0), 64'd0);
    issue(32'h00040000, 32'h80020000);

    // Randomized requests
    for (int i = 0; i < 60; i++) begin
      issue(rand_op($urandom_range(0, 3)), rand_op($urandom_range(0, 3)));
    end

    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("drain_empty", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
